// File: rtl/subexpr_operand_loader.sv
// rtl/subexpr_operand_loader.sv - serial-to-parallel operand loader for the subexpression datapath
//
// Collects four BW-bit words (a, b, c, d) from a valid/ready stream and presents
// them as one parallel frame that stays stable until downstream accepts it.
// Optional feature macro: LOADER_ZERO_CHECK_EN adds the b_zero output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream word handshake (in_ready is registered)
//   in_data             operand word
//   in_start            marks the word as the first operand (a) of a frame
//   a, b, c, d          assembled operands
//   out_valid/out_ready downstream frame handshake
//   frame_err           one-cycle pulse on a framing error
//   b_zero              (LOADER_ZERO_CHECK_EN only) b == 0 for the presented frame

module subexpr_operand_loader #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    input  logic          in_start,
    output logic [BW-1:0] a,
    output logic [BW-1:0] b,
    output logic [BW-1:0] c,
    output logic [BW-1:0] d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          frame_err
`ifdef LOADER_ZERO_CHECK_EN
    ,
    output logic          b_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
`ifdef LOADER_ZERO_CHECK_EN
            b_zero    <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // in_ready comes up here on the first edge after reset release
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (in_start) begin
                            a     <= in_data;
                            cnt   <= 2'd1;
                            state <= LOAD;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // A start word wins over completing the frame, even at cnt == 3
                        if (in_start) begin
                            a         <= in_data;
                            cnt       <= 2'd1;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                            case (cnt)
                                2'd1: b <= in_data;
                                2'd2: c <= in_data;
                                2'd3: begin
                                    d         <= in_data;
                                    state     <= HOLD;
                                    in_ready  <= 1'b0;
                                    out_valid <= 1'b1;
`ifdef LOADER_ZERO_CHECK_EN
                                    b_zero    <= (b == '0);
`endif
                                end
                                default: a <= in_data;
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
`ifdef LOADER_ZERO_CHECK_EN
                        b_zero    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 2'd0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subexpr_operand_loader.sv
// tb/tb_subexpr_operand_loader.sv - self-checking bench for subexpr_operand_loader

module tb_subexpr_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_start;
    logic [7:0] a, b, c, d;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
`ifdef LOADER_ZERO_CHECK_EN
    logic       b_zero;
`endif

    always #5 clk = ~clk;

    subexpr_operand_loader #(.BW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_start  (in_start),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err)
`ifdef LOADER_ZERO_CHECK_EN
        ,
        .b_zero    (b_zero)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: frame contents, word count of the frame in progress,
    // and whether a finished frame is being presented.
    logic [7:0] m_ops [4];
    int         m_n;
    bit         m_hold;
    bit         m_rdy;
    bit         m_err;
    bit         m_bz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ops[i] = 8'h00;
        m_n    = 0;
        m_hold = 0;
        m_rdy  = 0;
        m_err  = 0;
        m_bz   = 0;
    endtask

    task automatic model_edge(input bit v, input bit s, input logic [7:0] w, input bit ordy);
        bit acc;
        acc   = v && m_rdy;
        m_err = 0;
        if (m_hold) begin
            if (ordy) begin
                m_hold = 0;
                m_bz   = 0;
            end
        end else if (acc) begin
            if (s) begin
                m_err    = (m_n != 0);
                m_ops[0] = w;
                m_n      = 1;
            end else if (m_n == 0) begin
                m_err = 1;
            end else begin
                m_ops[m_n] = w;
                m_n++;
                if (m_n == 4) begin
                    m_n    = 0;
                    m_hold = 1;
                    m_bz   = (m_ops[1] == 8'h00);
                end
            end
        end
        m_rdy = !m_hold;
    endtask

    task automatic check_all();
        chk("in_ready",  32'(in_ready),  32'(m_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("a", 32'(a), 32'(m_ops[0]));
        chk("b", 32'(b), 32'(m_ops[1]));
        chk("c", 32'(c), 32'(m_ops[2]));
        chk("d", 32'(d), 32'(m_ops[3]));
`ifdef LOADER_ZERO_CHECK_EN
        chk("b_zero", 32'(b_zero), 32'(m_bz));
`endif
    endtask

    int err_seen = 0;

    task automatic cyc(input bit v, input bit s, input logic [7:0] w, input bit ordy);
        in_valid  = v;
        in_start  = s;
        in_data   = w;
        out_ready = ordy;
        @(posedge clk);
        model_edge(v, s, w, ordy);
        @(negedge clk);
        check_all();
        if (frame_err) err_seen++;
    endtask

    task automatic frame(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3, input bit ordy);
        cyc(1, 1, w0, ordy);
        cyc(1, 0, w1, ordy);
        cyc(1, 0, w2, ordy);
        cyc(1, 0, w3, ordy);
    endtask

    // Called at a falling edge; reset is asserted between clock edges.
    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_start  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // First edge after release raises in_ready
        cyc(0, 0, 8'h00, 1);
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Frame with downstream always ready
        frame(8'h11, 8'h22, 8'h33, 8'h44, 1);
        chk("p1_valid", 32'(out_valid), 32'd1);
        chk("p1_ready", 32'(in_ready), 32'd0);
        chk("p1_abcd", {a, b, c, d}, 32'h11223344);
        cyc(0, 0, 8'h00, 1);
        chk("p1_ready_back", 32'(in_ready), 32'd1);
        chk("p1_valid_drop", 32'(out_valid), 32'd0);

        // Frame held for 10 cycles with upstream still offering words
        frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, i[0], 8'($urandom), 0);
            chk("hold_abcd", {a, b, c, d}, 32'h11223344);
        end
        cyc(0, 0, 8'h00, 1);

        // Stray non-start word while idle
        err_seen = 0;
        cyc(1, 0, 8'h55, 1);
        chk("stray_err", 32'(frame_err), 32'd1);
        frame(8'h01, 8'h02, 8'h03, 8'h04, 1);
        chk("stray_err_once", 32'(err_seen), 32'd1);
        chk("p3_abcd", {a, b, c, d}, 32'h01020304);
        cyc(0, 0, 8'h00, 1);

        // Restart mid-frame
        err_seen = 0;
        cyc(1, 1, 8'h10, 1);
        cyc(1, 0, 8'h20, 1);
        frame(8'h30, 8'h40, 8'h50, 8'h60, 1);
        chk("restart_err_once", 32'(err_seen), 32'd1);
        chk("restart_abcd", {a, b, c, d}, 32'h30405060);
        cyc(0, 0, 8'h00, 1);

        // Restart when the next slot is d: must not enter HOLD
        cyc(1, 1, 8'h01, 1);
        cyc(1, 0, 8'h02, 1);
        cyc(1, 0, 8'h03, 1);
        cyc(1, 1, 8'h09, 1);
        chk("restart_at_d_valid", 32'(out_valid), 32'd0);
        chk("restart_at_d_a", 32'(a), 32'h09);
        cyc(1, 0, 8'h0a, 1);
        cyc(1, 0, 8'h0b, 1);
        cyc(1, 0, 8'h0c, 1);
        chk("restart_at_d_abcd", {a, b, c, d}, 32'h090a0b0c);
        cyc(0, 0, 8'h00, 1);

        // Reset mid-frame
        cyc(1, 1, 8'h77, 1);
        cyc(1, 0, 8'h88, 1);
        do_reset();
        chk("rst_abcd", {a, b, c, d}, 32'h0);
        cyc(0, 0, 8'h00, 1);
        frame(8'hA1, 8'hA2, 8'hA3, 8'hA4, 1);
        chk("post_rst_abcd", {a, b, c, d}, 32'hA1A2A3A4);
        cyc(0, 0, 8'h00, 1);

`ifdef LOADER_ZERO_CHECK_EN
        frame(8'h07, 8'h00, 8'h01, 8'h02, 1);
        chk("bz_set", 32'(b_zero), 32'd1);
        cyc(0, 0, 8'h00, 1);
        frame(8'h07, 8'h03, 8'h01, 8'h02, 1);
        chk("bz_clear", 32'(b_zero), 32'd0);
        cyc(0, 0, 8'h00, 1);
`endif

        // Randomized traffic with occasional mid-stream resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0,
                    ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                    $urandom_range(0, 2) != 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
